vliw_load_hazard_unit: RTL

- Parametrised successor of the single-load, single-consumer hazard detector.
- Tracks load results in flight to every architectural register with a per-register countdown scoreboard, so loads may have a multi-cycle latency.
- Checks every source operand of every slot in the IF/ID bundle against all loads issuing from any slot.
- Drives PC/IF-ID write enables and the ID/EX bubble select; sits between the decode stage and the ID/EX pipeline register.

---
 rtl/vliw_pkg.sv | 33 +++
 rtl/load_scoreboard.sv | 67 ++++++
 rtl/vliw_load_hazard_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW load-use hazard unit.
// Contents:
//   DEF_NUM_SLOTS / DEF_REG_ADDR_W : default bundle geometry
//   src_field_e                    : operand field selector (Rn, Rm, store-data Rd)
//   slot_field()                   : extracts slot s of a packed per-slot vector
package vliw_pkg;

  localparam int unsigned DEF_NUM_SLOTS  = 2;
  localparam int unsigned DEF_REG_ADDR_W = 3;
  localparam int unsigned NUM_FIELDS     = 3;

  // Widest packed per-slot vector / field that slot_field() handles.
  localparam int unsigned FIELD_VEC_W = 64;
  localparam int unsigned FIELD_MAX_W = 8;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_C = 2'd2
  } src_field_e;

  // Returns the w-bit field of slot s, i.e. vec[s*w +: w], zero-extended.
  function automatic logic [FIELD_MAX_W-1:0] slot_field(
    input logic [FIELD_VEC_W-1:0] vec,
    input int unsigned            s,
    input int unsigned            w
  );
    logic [FIELD_VEC_W-1:0] shifted;
    shifted = vec >> (s * w);
    return FIELD_MAX_W'(shifted) & ((FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1));
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Per-register countdown of load results still in flight.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load_valid      : slot s in EX holds a load
//   load_rd         : destination of each EX load, slot s at [s*REG_ADDR_W +: REG_ADDR_W]
//   busy            : bit r set while register r's counter is nonzero
module load_scoreboard
  import vliw_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SLOTS-1:0]            load_valid,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] load_rd,
  output logic [(2**REG_ADDR_W)-1:0]      busy
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W    = $clog2(LOAD_LAT) + 1;

  logic [CNT_W-1:0]    ctr_q [NUM_REGS];
  logic [CNT_W-1:0]    ctr_d [NUM_REGS];
  logic [NUM_REGS-1:0] set_hit;

  // Decode which registers receive a new load this cycle (duplicates collapse).
  always_comb begin
    set_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int t = 0; t < NUM_SLOTS; t++) begin
        if (load_valid[t] &&
            (REG_ADDR_W'(slot_field(FIELD_VEC_W'(load_rd), t, REG_ADDR_W)) == REG_ADDR_W'(r))) begin
          set_hit[r] = 1'b1;
        end
      end
    end
  end

  // Reload beats decrement, even on an already nonzero counter.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      ctr_d[r] = ctr_q[r];
      if (set_hit[r]) begin
        ctr_d[r] = CNT_W'(LOAD_LAT - 1);
      end else if (ctr_q[r] != '0) begin
        ctr_d[r] = ctr_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) ctr_q[r] <= '0;
      else       ctr_q[r] <= ctr_d[r];
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (ctr_q[r] != '0);
    end
  end

endmodule

// File: rtl/vliw_load_hazard_unit.sv
// Load-use hazard detector for a VLIW bundle in IF/ID against loads in ID/EX.
// Optional feature macro: HAZ_STALL_PERF_EN (stall_cycles / longest_stall counters).
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   ex_load_valid, ex_load_rd   : per-slot loads in ID/EX and their destinations
//   id_src_a/b/c, id_use_a/b/c  : per-slot source fields in IF/ID and their used bits
//   id_flush                    : IF/ID bundle squashed this cycle
//   stall, pc_write, if_id_write, id_ex_bubble : pipeline control
//   stall_slot_mask             : slots whose operands caused the stall
//   stall_cycles, longest_stall : performance counters (HAZ_STALL_PERF_EN only)
module vliw_load_hazard_unit
  import vliw_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SLOTS-1:0]            ex_load_valid,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] ex_load_rd,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_src_a,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_src_b,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_src_c,
  input  logic [NUM_SLOTS-1:0]            id_use_a,
  input  logic [NUM_SLOTS-1:0]            id_use_b,
  input  logic [NUM_SLOTS-1:0]            id_use_c,
  input  logic                            id_flush,
  output logic                            stall,
  output logic                            pc_write,
  output logic                            if_id_write,
  output logic                            id_ex_bubble,
  output logic [NUM_SLOTS-1:0]            stall_slot_mask
`ifdef HAZ_STALL_PERF_EN
  ,
  output logic [15:0]                     stall_cycles,
  output logic [7:0]                      longest_stall
`endif
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic [NUM_REGS-1:0]             busy;
  logic [NUM_SLOTS*REG_ADDR_W-1:0] src_vec [NUM_FIELDS];
  logic [NUM_SLOTS-1:0]            use_vec [NUM_FIELDS];
  logic [NUM_SLOTS-1:0]            haz_mask;

  load_scoreboard #(
    .NUM_SLOTS  (NUM_SLOTS),
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_LAT   (LOAD_LAT)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (ex_load_valid),
    .load_rd    (ex_load_rd),
    .busy       (busy)
  );

  assign src_vec[SRC_A] = id_src_a;
  assign src_vec[SRC_B] = id_src_b;
  assign src_vec[SRC_C] = id_src_c;
  assign use_vec[SRC_A] = id_use_a;
  assign use_vec[SRC_B] = id_use_b;
  assign use_vec[SRC_C] = id_use_c;

  // Operand hazard: tracked load still pending, or a load to it sitting in EX right now.
  always_comb begin
    logic [REG_ADDR_W-1:0] src;
    logic                  load_hit;
    haz_mask = '0;
    src      = '0;
    load_hit = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        src      = REG_ADDR_W'(slot_field(FIELD_VEC_W'(src_vec[f]), s, REG_ADDR_W));
        load_hit = 1'b0;
        for (int t = 0; t < NUM_SLOTS; t++) begin
          if (ex_load_valid[t] &&
              (REG_ADDR_W'(slot_field(FIELD_VEC_W'(ex_load_rd), t, REG_ADDR_W)) == src)) begin
            load_hit = 1'b1;
          end
        end
        if (use_vec[f][s] && (busy[src] || load_hit)) begin
          haz_mask[s] = 1'b1;
        end
      end
    end
  end

  // A squashed bundle or reset never stalls.
  always_comb begin
    stall           = 1'b0;
    stall_slot_mask = '0;
    if (!reset && !id_flush) begin
      stall_slot_mask = haz_mask;
      stall           = |haz_mask;
    end
    pc_write     = ~stall;
    if_id_write  = ~stall;
    id_ex_bubble = stall;
  end

`ifdef HAZ_STALL_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  run_len_q, run_len_d;
  logic [7:0]  longest_q, longest_d;

  // Total stall cycles and longest run; a run is scored on its first non-stall cycle.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    run_len_d      = run_len_q;
    longest_d      = longest_q;
    if (stall) begin
      if (stall_cycles_q != 16'hFFFF) stall_cycles_d = stall_cycles_q + 16'd1;
      if (run_len_q != 8'hFF)         run_len_d      = run_len_q + 8'd1;
    end else begin
      if (run_len_q > longest_q) longest_d = run_len_q;
      run_len_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      run_len_q      <= '0;
      longest_q      <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      run_len_q      <= run_len_d;
      longest_q      <= longest_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign longest_stall = longest_q;
`else
  // Performance counters not built.
`endif

endmodule
